// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receive FSM states, channel select and the default word
// width used by both the receive and transmit controllers.
package i2s_pkg;

    localparam int unsigned I2S_WIDTH = 24;

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, PAD} rx_state_t;

    typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} chan_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// N-stage synchroniser for an asynchronous pin, plus a delayed copy used to
// detect rising edges and any change of the synchronised level.
module i2s_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic change_o
);
    import i2s_pkg::*;

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level_o  = sync_q[STAGES-1];
    assign rise_o   = sync_q[STAGES-1] & ~dly_q;
    assign change_o = sync_q[STAGES-1] ^ dly_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversampled bclk/lrclk/sdata, left-then-right capture, valid/ready
// holding register. Optional peak meters enabled by defining I2S_RX_PEAK_EN.
module i2s_rx #(
    parameter int unsigned WIDTH       = i2s_pkg::I2S_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bclk,
    input  logic             lrclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] out_l,
    output logic [WIDTH-1:0] out_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err
`ifdef I2S_RX_PEAK_EN
    ,
    input  logic             peak_clr,
    output logic [WIDTH-2:0] peak_l,
    output logic [WIDTH-2:0] peak_r
`endif
);
    import i2s_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic bclk_rise, lr_level, lr_change, sd_level;
    logic bclk_level_unused, bclk_chg_unused, lr_rise_unused, sd_rise_unused, sd_chg_unused;

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk_i(clk), .rst_i(rst), .d_i(bclk),
        .level_o(bclk_level_unused), .rise_o(bclk_rise), .change_o(bclk_chg_unused)
    );
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk_i(clk), .rst_i(rst), .d_i(lrclk),
        .level_o(lr_level), .rise_o(lr_rise_unused), .change_o(lr_change)
    );
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk_i(clk), .rst_i(rst), .d_i(sdata),
        .level_o(sd_level), .rise_o(sd_rise_unused), .change_o(sd_chg_unused)
    );

    rx_state_t        state_q;
    chan_t            chan_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-2:0] shift_q;
    logic [WIDTH-1:0] stage_l_q, shift_d;
    logic             left_staged_q, frame_err_q, last_bit, complete_d;

    assign shift_d    = {shift_q, sd_level};
    assign last_bit   = (cnt_q == CW'(WIDTH - 1));
    // The right word completes a frame only when its own left word is still staged.
    assign complete_d = (state_q == SHIFT) && !lr_change && bclk_rise && last_bit
                        && (chan_q == RIGHT) && left_staged_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            chan_q        <= LEFT;
            cnt_q         <= '0;
            shift_q       <= '0;
            stage_l_q     <= '0;
            left_staged_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                IDLE: if (lr_change && !lr_level) begin
                    state_q <= SKIP;
                    chan_q  <= LEFT;
                end
                SKIP: if (bclk_rise) begin
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: if (lr_change) begin
                    frame_err_q   <= 1'b1;
                    left_staged_q <= 1'b0;
                    chan_q        <= LEFT;
                    state_q       <= lr_level ? IDLE : SKIP;
                end else if (bclk_rise) begin
                    shift_q <= shift_d[WIDTH-2:0];
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        state_q <= PAD;
                        if (chan_q == LEFT) begin
                            stage_l_q     <= shift_d;
                            left_staged_q <= 1'b1;
                        end else begin
                            left_staged_q <= 1'b0;
                        end
                    end
                end
                PAD: if (lr_change) begin
                    state_q <= SKIP;
                    chan_q  <= chan_t'(~chan_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [WIDTH-1:0] out_l_q, out_r_q;
    logic             out_valid_q, overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (complete_d) begin
                out_l_q     <= stage_l_q;
                out_r_q     <= shift_d;
                out_valid_q <= 1'b1;
                overrun_q   <= out_valid_q && !out_ready;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

`ifdef I2S_RX_PEAK_EN
    function automatic logic [WIDTH-2:0] magnitude(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] n;
        n = -x;
        if (!x[WIDTH-1]) return x[WIDTH-2:0];
        if (n[WIDTH-1])  return '1;
        return n[WIDTH-2:0];
    endfunction

    logic [WIDTH-2:0] mag_l_d, mag_r_d, peak_l_q, peak_r_q;
    assign mag_l_d = magnitude(stage_l_q);
    assign mag_r_d = magnitude(shift_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else if (complete_d) begin
            peak_l_q <= (peak_clr || mag_l_d > peak_l_q) ? mag_l_d : peak_l_q;
            peak_r_q <= (peak_clr || mag_r_d > peak_r_q) ? mag_r_d : peak_r_q;
        end else if (peak_clr) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end
    end

    assign peak_l = peak_l_q;
    assign peak_r = peak_r_q;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: table-driven frames, directed handshake/reset
// corners, and a randomized frame stream checked against a frame-level model.
module tb_i2s_rx;
    localparam int unsigned W = 24;

    logic clk = 1'b0, rst = 1'b1, bclk = 1'b0, lrclk = 1'b1, sdata = 1'b0, out_ready = 1'b0;
    logic [W-1:0] out_l, out_r;
    logic out_valid, overrun, frame_err;
`ifdef I2S_RX_PEAK_EN
    logic peak_clr = 1'b0;
    logic [W-2:0] peak_l, peak_r;
`endif

    int unsigned errors = 0, checks = 0;
    int unsigned n_ovr = 0, n_ferr = 0;
    logic [2*W-1:0] got[$];
    logic [2*W-1:0] expq[$];

    always #5 clk = ~clk;

    i2s_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .frame_err(frame_err)
`ifdef I2S_RX_PEAK_EN
        , .peak_clr(peak_clr), .peak_l(peak_l), .peak_r(peak_r)
`endif
    );

    // Consumer side: record every accepted pair and count event pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) got.push_back({out_l, out_r});
            if (overrun)   n_ovr++;
            if (frame_err) n_ferr++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One slot: index 0 is the I2S delay bit, 1..W carry the word MSB first.
    // accept_bit pulses out_ready for exactly the cycle that should complete the frame.
    task automatic send_slot(input logic lr, input logic [W-1:0] word, input int nbits,
                             input int accept_bit);
        for (int i = 0; i < nbits; i++) begin
            bclk = 1'b0;
            if (i == 0) lrclk = lr;
            if (i >= 1 && i <= int'(W)) sdata = word[W-i];
            else sdata = 1'($urandom);
            tick(16);
            bclk = 1'b1;
            if (i == accept_bit) begin
                tick(2);
                out_ready = 1'b1;
                tick(1);
                out_ready = 1'b0;
                tick(13);
            end else begin
                tick(16);
            end
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                              input int lb, input int rb, input int acc);
        send_slot(1'b0, l, lb, -1);
        send_slot(1'b1, r, rb, acc);
    endtask

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           lb;
        int           rb;
        logic         exp_pair;
        int           exp_ferr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int unsigned base_got, base_ovr, base_ferr;
        logic [W-1:0] rl, rr;
        int lb, rb, cut;

        // A right slot cut is only flagged when the next left slot starts, so its
        // frame_err is expected in the following entry.
        tbl[0] = '{24'h123456, 24'hABCDEF, 32, 32, 1'b1, 0};
        tbl[1] = '{24'hFFFFFF, 24'h000000, 32, 32, 1'b1, 0};
        tbl[2] = '{24'h0A0A0A, 24'h5A5A5A, 32, 11, 1'b0, 0};
        tbl[3] = '{24'h800000, 24'h7FFFFF, 25, 25, 1'b1, 1};
        tbl[4] = '{24'h111111, 24'h222222, 6,  32, 1'b0, 1};
        tbl[5] = '{24'hC0FFEE, 24'h00BEEF, 32, 32, 1'b1, 0};

        tick(4);
        chk("reset out_l", 64'(out_l), 64'h0);
        chk("reset out_r", 64'(out_r), 64'h0);
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset overrun", 64'(overrun), 64'h0);
        chk("reset frame_err", 64'(frame_err), 64'h0);
        rst = 1'b0;
        tick(4);

        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            base_got = got.size(); base_ovr = n_ovr; base_ferr = n_ferr;
            send_frame(tbl[k].l, tbl[k].r, tbl[k].lb, tbl[k].rb, -1);
            tick(8);
            chk($sformatf("tbl%0d pairs", k), 64'(got.size() - base_got), 64'(tbl[k].exp_pair));
            if (tbl[k].exp_pair && got.size() > base_got)
                chk($sformatf("tbl%0d data", k), 64'(got[$]), 64'({tbl[k].l, tbl[k].r}));
            chk($sformatf("tbl%0d frame_err", k), 64'(n_ferr - base_ferr), 64'(tbl[k].exp_ferr));
            chk($sformatf("tbl%0d overrun", k), 64'(n_ovr - base_ovr), 64'h0);
        end

`ifdef I2S_RX_PEAK_EN
        peak_clr = 1'b1; tick(1); peak_clr = 1'b0; tick(1);
        chk("peak clr l", 64'(peak_l), 64'h0);
        chk("peak clr r", 64'(peak_r), 64'h0);
        send_frame(24'hFFFFFB, 24'h000002, 32, 32, -1); tick(8);
        chk("peak -5", 64'(peak_l), 64'h5);
        send_frame(24'h000003, 24'h000000, 32, 32, -1); tick(8);
        chk("peak keep", 64'(peak_l), 64'h5);
        chk("peak r", 64'(peak_r), 64'h2);
        send_frame(24'h800000, 24'h000001, 32, 32, -1); tick(8);
        chk("peak sat", 64'(peak_l), 64'h7FFFFF);
        peak_clr = 1'b1; tick(1); peak_clr = 1'b0; tick(1);
        chk("peak clr again", 64'(peak_l), 64'h0);
`endif

        // Consumer stalls across two frames: B overwrites A with one overrun.
        out_ready = 1'b0;
        base_got = got.size(); base_ovr = n_ovr;
        send_frame(24'hA0A0A1, 24'hA1A1A2, 32, 32, -1);
        send_frame(24'hB0B0B1, 24'hB1B1B2, 32, 32, -1);
        tick(8);
        chk("ovr valid held", 64'(out_valid), 64'h1);
        chk("ovr pulses", 64'(n_ovr - base_ovr), 64'h1);
        chk("ovr data", 64'({out_l, out_r}), 64'({24'hB0B0B1, 24'hB1B1B2}));
        chk("ovr none taken", 64'(got.size() - base_got), 64'h0);
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        @(negedge clk);
        chk("ovr valid cleared", 64'(out_valid), 64'h0);
        chk("ovr one taken", 64'(got.size() - base_got), 64'h1);
        if (got.size() > base_got) chk("ovr taken data", 64'(got[$]), 64'({24'hB0B0B1, 24'hB1B1B2}));
        tick(1);

        // Acceptance in the exact completion cycle of the next frame.
        base_ovr = n_ovr; base_got = got.size();
        send_frame(24'hC1C2C3, 24'hC4C5C6, 32, 32, -1);
        send_frame(24'hD1D2D3, 24'hD4D5D6, 32, 32, W);
        tick(4);
        chk("same valid", 64'(out_valid), 64'h1);
        chk("same data", 64'({out_l, out_r}), 64'({24'hD1D2D3, 24'hD4D5D6}));
        chk("same overrun", 64'(n_ovr - base_ovr), 64'h0);
        chk("same taken", 64'(got.size() - base_got), 64'h1);
        if (got.size() > base_got) chk("same taken data", 64'(got[$]), 64'({24'hC1C2C3, 24'hC4C5C6}));

        // Reset in the middle of a left slot, then restart in a right slot.
        send_slot(1'b0, 24'h5E5E5E, 12, -1);
        rst = 1'b1; #1;
        chk("rst valid", 64'(out_valid), 64'h0);
        chk("rst data", 64'({out_l, out_r}), 64'h0);
        tick(3); rst = 1'b0; tick(2);
        base_got = got.size(); base_ferr = n_ferr;
        out_ready = 1'b1;
        send_slot(1'b1, 24'h999999, 32, -1);
        send_frame(24'hE1E2E3, 24'hE4E5E6, 32, 32, -1);
        tick(8);
        chk("rst pairs", 64'(got.size() - base_got), 64'h1);
        if (got.size() > base_got) chk("rst first pair", 64'(got[$]), 64'({24'hE1E2E3, 24'hE4E5E6}));
        chk("rst frame_err", 64'(n_ferr - base_ferr), 64'h0);

        // Random frames: a frame is delivered iff both slots carry all W bits.
        base_got = got.size(); base_ovr = n_ovr; base_ferr = n_ferr;
        expq.delete();
        cut = 0;
        for (int k = 0; k < 6; k++) begin
            int c;
            rl = W'($urandom); rr = W'($urandom);
            c  = int'($urandom_range(0, 3));
            lb = (c == 0) ? 1 + int'($urandom_range(1, W - 1)) : int'($urandom_range(W + 1, 32));
            rb = (c == 1) ? 1 + int'($urandom_range(1, W - 1)) : int'($urandom_range(W + 1, 32));
            if (c < 2) cut++;
            else expq.push_back({rl, rr});
            send_frame(rl, rr, lb, rb, -1);
        end
        rl = W'($urandom); rr = W'($urandom);
        expq.push_back({rl, rr});
        send_frame(rl, rr, 32, 32, -1);
        tick(8);
        chk("rand pairs", 64'(got.size() - base_got), 64'(expq.size()));
        for (int k = 0; k < expq.size() && base_got + k < got.size(); k++)
            chk($sformatf("rand pair%0d", k), 64'(got[base_got + k]), 64'(expq[k]));
        chk("rand frame_err", 64'(n_ferr - base_ferr), 64'(cut));
        chk("rand overrun", 64'(n_ovr - base_ovr), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
